ram_port_arbiter: RTL

- Shares the single data-RAM port between the CPU and one external requester (loader/debug host).
- Sits between the CPU's RAM control/address/data signals and the ram instance. Owns the muxed RAM control lines.
- Grants the external side only at CPU instruction boundaries, by stalling the CPU with cpu_hold.
- A burst cap and a fairness rule stop the external side from starving the CPU.

---
 rtl/ram_port_arbiter_pkg.sv | 15 +
 rtl/ram_port_arbiter_if.sv | 40 ++++
 rtl/ram_port_arbiter_burst_counter.sv | 39 +++
 rtl/ram_port_arbiter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and defaults for the RAM port arbiter between the CPU and an
// external loader/debug host.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    CPU_OWN  = 2'd0,
    WAIT_BND = 2'd1,
    EXT_OWN  = 2'd2,
    RELEASE  = 2'd3
  } arb_state_e;

  localparam int MAX_BURST_DEFAULT = 8;
  localparam int AW_DEFAULT        = 8;

endpackage : ram_port_arbiter_pkg

// File: rtl/ram_port_arbiter_if.sv
// Bundles the CPU, external requester and RAM-side signals of the arbiter.
// slave is the arbiter's view, master the surrounding system's view.
interface ram_port_arbiter_if #(
  parameter int AW = 8
);

  logic          cpu_boundary;
  logic          cpu_ram_rd;
  logic          cpu_ram_wr;
  logic [AW-1:0] cpu_addr;
  logic          ext_req;
  logic          ext_wr;
  logic [AW-1:0] ext_addr;
  logic [7:0]    ext_wdata;
  logic [7:0]    ram_rdata;
  logic          ram_rd;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic          ext_wdata_oe;
  logic          cpu_hold;
  logic          ext_gnt;
  logic [7:0]    ext_rdata;
  logic          ext_rvalid;
  logic          conflict;

  modport slave (
    input  cpu_boundary, cpu_ram_rd, cpu_ram_wr, cpu_addr,
    input  ext_req, ext_wr, ext_addr, ext_wdata, ram_rdata,
    output ram_rd, ram_wr, ram_addr, ext_wdata_oe,
    output cpu_hold, ext_gnt, ext_rdata, ext_rvalid, conflict
  );

  modport master (
    output cpu_boundary, cpu_ram_rd, cpu_ram_wr, cpu_addr,
    output ext_req, ext_wr, ext_addr, ext_wdata, ram_rdata,
    input  ram_rd, ram_wr, ram_addr, ext_wdata_oe,
    input  cpu_hold, ext_gnt, ext_rdata, ext_rvalid, conflict
  );

endinterface : ram_port_arbiter_if

// File: rtl/ram_port_arbiter_burst_counter.sv
// Counts external accesses within one grant; tc flags the access that makes
// the count reach MAX_BURST so the arbiter can release in that same cycle.
module ram_port_arbiter_burst_counter #(
  parameter int MAX_BURST = 8
) (
  input  logic clk,
  input  logic resetBar,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 8'd0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end
  end

  assign tc = en && ((count_q + 8'd1) == MAX_BURST_C);

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : ram_port_arbiter_burst_counter

// File: rtl/ram_port_arbiter.sv
// Shares the data-RAM port between the CPU and an external requester, handing
// the port over only at CPU instruction boundaries and capping each burst.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT,
  parameter int AW        = AW_DEFAULT
) (
  input  logic               clk,
  input  logic               resetBar,
  ram_port_arbiter_if.slave  bus
);

  arb_state_e    state_q, state_d;
  logic          owed_q, owed_d;
  logic [7:0]    ext_rdata_q, ext_rdata_d;
  logic          ext_rvalid_q, ext_rvalid_d;
  logic          conflict_q, conflict_d;

  logic          ram_rd_d;
  logic          ram_wr_d;
  logic [AW-1:0] ram_addr_d;
  logic          ext_wdata_oe_d;
  logic          cpu_hold_d;
  logic          ext_gnt_d;
  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_tc;
  logic          rd_capture;

  ram_port_arbiter_burst_counter #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_counter (
    .clk      (clk),
    .resetBar (resetBar),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .tc       (cnt_tc)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    owed_d         = owed_q;
    ram_rd_d       = 1'b0;
    ram_wr_d       = 1'b0;
    ram_addr_d     = '0;
    ext_wdata_oe_d = 1'b0;
    cpu_hold_d     = 1'b0;
    ext_gnt_d      = 1'b0;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;

    unique case (state_q)
      CPU_OWN: begin
        ram_rd_d   = bus.cpu_ram_rd;
        ram_wr_d   = bus.cpu_ram_wr;
        ram_addr_d = bus.cpu_addr;
        // After a capped burst the CPU must retire one instruction first.
        if (owed_q) begin
          if (bus.cpu_boundary) owed_d = 1'b0;
        end else if (bus.ext_req) begin
          state_d = WAIT_BND;
        end
      end
      WAIT_BND: begin
        ram_rd_d   = bus.cpu_ram_rd;
        ram_wr_d   = bus.cpu_ram_wr;
        ram_addr_d = bus.cpu_addr;
        if (!bus.ext_req) begin
          state_d = CPU_OWN;
        end else if (bus.cpu_boundary) begin
          state_d = EXT_OWN;
        end
      end
      EXT_OWN: begin
        cpu_hold_d     = 1'b1;
        ext_gnt_d      = 1'b1;
        ram_addr_d     = bus.ext_addr;
        ram_wr_d       = bus.ext_req & bus.ext_wr;
        ram_rd_d       = bus.ext_req & ~bus.ext_wr;
        ext_wdata_oe_d = bus.ext_req & bus.ext_wr;
        cnt_en         = bus.ext_req;
        if (!bus.ext_req) begin
          state_d = RELEASE;
        end else if (cnt_tc) begin
          state_d = RELEASE;
          owed_d  = 1'b1;
        end
      end
      RELEASE: begin
        cnt_clr = 1'b1;
        state_d = CPU_OWN;
      end
      default: state_d = CPU_OWN;
    endcase
  end

  assign rd_capture   = (state_q == EXT_OWN) && bus.ext_req && !bus.ext_wr;
  assign ext_rdata_d  = rd_capture ? bus.ram_rdata : ext_rdata_q;
  assign ext_rvalid_d = rd_capture;
  assign conflict_d   = conflict_q | (cpu_hold_d & (bus.cpu_ram_rd | bus.cpu_ram_wr));

  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state_q      <= CPU_OWN;
      owed_q       <= 1'b0;
      ext_rdata_q  <= 8'h00;
      ext_rvalid_q <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owed_q       <= owed_d;
      ext_rdata_q  <= ext_rdata_d;
      ext_rvalid_q <= ext_rvalid_d;
      conflict_q   <= conflict_d;
    end
  end

  assign bus.ram_rd       = ram_rd_d;
  assign bus.ram_wr       = ram_wr_d;
  assign bus.ram_addr     = ram_addr_d;
  assign bus.ext_wdata_oe = ext_wdata_oe_d;
  assign bus.cpu_hold     = cpu_hold_d;
  assign bus.ext_gnt      = ext_gnt_d;
  assign bus.ext_rdata    = ext_rdata_q;
  assign bus.ext_rvalid   = ext_rvalid_q;
  assign bus.conflict     = conflict_q;

endmodule : ram_port_arbiter
